// File: rtl/cr_alloc_regs.sv
// cr_alloc_regs: double-buffered cognitive-radio allocation register block.
// The bus master selects a standard, streams the allocation vector into a
// shadow register one DW-bit word at a time, and the TX datapath commits the
// shadow to ALLOC_VEC with VEC_LD once the per-standard word count is reached.
// Optional readback of CTRL/STATUS is built when CR_REGS_READBACK_EN is defined;
// otherwise DAT_O is tied to zero.
module cr_alloc_regs #(
  parameter int DW    = 32,
  parameter int VEC_W = 4096,
  parameter int CNT_W = 8,
  parameter int LEN0  = 4,
  parameter int LEN1  = 16,
  parameter int LEN2  = 128,
  parameter int LEN3  = 0
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [DW-1:0]    DAT_I,
  output logic [DW-1:0]    DAT_O,
  input  logic [1:0]       ADR_I,
  input  logic             WE_I,
  input  logic             STB_I,
  output logic             ACK_O,
  input  logic             VEC_LD,
  output logic [1:0]       STD,
  output logic [VEC_W-1:0] ALLOC_VEC,
  output logic             VEC_VLD,
  output logic             VEC_FULL
);

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_VEC    = 2'd1;
  localparam logic [1:0] ADR_CLR    = 2'd2;
  localparam logic [1:0] ADR_STATUS = 2'd3;

  logic [1:0]       std_reg,    std_next;
  logic [VEC_W-1:0] shadow_reg, shadow_next;
  logic [VEC_W-1:0] alloc_reg,  alloc_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic             ld_err_reg, ld_err_next;
  logic             vld_reg,    vld_next;

  logic [CNT_W-1:0] len_sel;
  logic [VEC_W-1:0] shadow_shift;
  logic             full;
  logic             wr;

  // Word count required to fill the shadow for the active standard.
  always_comb begin
    len_sel = CNT_W'(LEN0);
    case (std_reg)
      2'd0:    len_sel = CNT_W'(LEN0);
      2'd1:    len_sel = CNT_W'(LEN1);
      2'd2:    len_sel = CNT_W'(LEN2);
      default: len_sel = CNT_W'(LEN3);
    endcase
  end

  assign full = (cnt_reg == len_sel);
  assign wr   = STB_I & WE_I;

  // Only a VEC access against a full shadow is stalled; everything else acks at once.
  assign ACK_O = (STB_I && (ADR_I == ADR_VEC)) ? ~full : 1'b1;

  // New words enter at the bottom so the first word ends up highest after a fill.
  generate
    if (VEC_W == DW) begin : g_shift_single
      assign shadow_shift = DAT_I;
    end else begin : g_shift_multi
      assign shadow_shift = {shadow_reg[VEC_W-DW-1:0], DAT_I};
    end
  endgenerate

  // Next-state: commit first, then bus writes so CTRL/CLR override cnt/shadow/ld_err.
  always_comb begin
    std_next    = std_reg;
    shadow_next = shadow_reg;
    alloc_next  = alloc_reg;
    cnt_next    = cnt_reg;
    ld_err_next = ld_err_reg;
    vld_next    = 1'b0;

    if (VEC_LD) begin
      if (full) begin
        alloc_next = shadow_reg;
        vld_next   = 1'b1;
        cnt_next   = '0;
      end else begin
        ld_err_next = 1'b1;
      end
    end

    if (wr) begin
      case (ADR_I)
        ADR_CTRL: begin
          std_next    = DAT_I[1:0];
          cnt_next    = '0;
          shadow_next = '0;
          ld_err_next = 1'b0;
        end
        ADR_VEC: begin
          if (!full) begin
            shadow_next = shadow_shift;
            cnt_next    = cnt_reg + 1'b1;
          end
        end
        ADR_CLR: begin
          cnt_next    = '0;
          shadow_next = '0;
          ld_err_next = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset that overrides any same-cycle event.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      std_reg    <= '0;
      shadow_reg <= '0;
      alloc_reg  <= '0;
      cnt_reg    <= '0;
      ld_err_reg <= 1'b0;
      vld_reg    <= 1'b0;
    end else begin
      std_reg    <= std_next;
      shadow_reg <= shadow_next;
      alloc_reg  <= alloc_next;
      cnt_reg    <= cnt_next;
      ld_err_reg <= ld_err_next;
      vld_reg    <= vld_next;
    end
  end

  assign STD       = std_reg;
  assign ALLOC_VEC = alloc_reg;
  assign VEC_VLD   = vld_reg;
  assign VEC_FULL  = full;

`ifdef CR_REGS_READBACK_EN
  // Combinational readback of CTRL and STATUS; other addresses read zero.
  always_comb begin
    DAT_O = '0;
    case (ADR_I)
      ADR_CTRL: DAT_O[1:0] = std_reg;
      ADR_STATUS: begin
        DAT_O[CNT_W-1:0] = cnt_reg;
        DAT_O[DW-1]      = full;
        DAT_O[DW-2]      = ld_err_reg;
        DAT_O[DW-3:DW-4] = std_reg;
      end
      default: ;
    endcase
  end
`else
  assign DAT_O = '0;
`endif

endmodule

// File: tb/tb_cr_alloc_regs.sv
// Self-checking bench for cr_alloc_regs: commits are predicted into a queue
// when VEC_LD is driven and compared word by word when VEC_VLD pulses.
module tb_cr_alloc_regs;

  localparam int DW    = 32;
  localparam int VEC_W = 4096;
  localparam int CNT_W = 8;
  localparam int NW    = VEC_W / DW;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    dat_i;
  logic [DW-1:0]    dat_o;
  logic [1:0]       adr;
  logic             we;
  logic             stb;
  logic             ack;
  logic             vec_ld;
  logic [1:0]       std_o;
  logic [VEC_W-1:0] alloc_vec;
  logic             vec_vld;
  logic             vec_full;

  int checks = 0;
  int errors = 0;

  logic [VEC_W-1:0] exp_q[$];
  logic [VEC_W-1:0] exp_v;
  logic [VEC_W-1:0] model_shadow;

  cr_alloc_regs #(
    .DW(DW), .VEC_W(VEC_W), .CNT_W(CNT_W),
    .LEN0(4), .LEN1(16), .LEN2(128), .LEN3(0)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .DAT_I(dat_i),
    .DAT_O(dat_o),
    .ADR_I(adr),
    .WE_I(we),
    .STB_I(stb),
    .ACK_O(ack),
    .VEC_LD(vec_ld),
    .STD(std_o),
    .ALLOC_VEC(alloc_vec),
    .VEC_VLD(vec_vld),
    .VEC_FULL(vec_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every VEC_VLD pulse must match the oldest predicted commit.
  always @(negedge clk) begin
    if (vec_vld === 1'b1) begin
      check("vld_pending", 32'(vec_vld), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        $display("COMMIT seen at %0t", $time);
        for (int w = 0; w < NW; w++)
          check("alloc_word", alloc_vec[w*DW +: DW], exp_v[w*DW +: DW]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    stb    = 1'b0;
    we     = 1'b0;
    vec_ld = 1'b0;
    adr    = 2'd0;
    dat_i  = '0;
  endtask

  task automatic ctrl_write(input logic [1:0] s);
    adr = 2'd0; dat_i = 32'(s); stb = 1'b1; we = 1'b1;
    $display("WR CTRL std=%0d", s);
    tick();
    idle();
    model_shadow = '0;
  endtask

  task automatic clr_write();
    adr = 2'd2; stb = 1'b1; we = 1'b1;
    $display("WR CLR");
    tick();
    idle();
    model_shadow = '0;
  endtask

  task automatic vec_write(input logic [DW-1:0] d);
    adr = 2'd1; dat_i = d; stb = 1'b1; we = 1'b1;
    $display("WR VEC dat=%h", d);
    sample();
    check("ack_vec", 32'(ack), 32'd1);
    tick();
    idle();
    model_shadow = {model_shadow[VEC_W-DW-1:0], d};
  endtask

  task automatic commit(input bit expect_ok);
    vec_ld = 1'b1;
    if (expect_ok) exp_q.push_back(model_shadow);
    $display("VEC_LD expect_commit=%0d", expect_ok);
    tick();
    vec_ld = 1'b0;
  endtask

  task automatic read_status(input logic [DW-1:0] exp_word, input string tag);
    adr = 2'd3; stb = 1'b1; we = 1'b0;
    sample();
`ifdef CR_REGS_READBACK_EN
    check(tag, dat_o, exp_word);
`else
    check(tag, dat_o, 32'd0);
    if (exp_word == 32'hFFFF_FFFF) $display("status word not built");
`endif
    $display("RD STATUS dat=%h", dat_o);
    tick();
    idle();
  endtask

  initial begin
    idle();
    model_shadow = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    sample();
    check("rst_std",  32'(std_o),    32'd0);
    check("rst_full", 32'(vec_full), 32'd0);
    check("rst_vld",  32'(vec_vld),  32'd0);
    check("rst_ack",  32'(ack),      32'd1);
    check("rst_alloc_lo", alloc_vec[31:0],       32'd0);
    check("rst_alloc_hi", alloc_vec[4095:4064],  32'd0);

    // 1: STD=1, 16 words, commit.
    tick();
    ctrl_write(2'd1);
    sample();
    check("t1_std", 32'(std_o), 32'd1);
    tick();
    for (int i = 1; i <= 16; i++) begin
      vec_write(32'(i));
      sample();
      check("t1_full", 32'(vec_full), 32'(i == 16));
      tick();
    end
    commit(1'b1);
    sample();
    check("t1_vld",      32'(vec_vld),      32'd1);
    check("t1_first",    alloc_vec[511:480], 32'h1);
    check("t1_last",     alloc_vec[31:0],    32'h10);
    check("t1_cnt_zero", 32'(vec_full),      32'd0);
    tick();
    sample();
    check("t1_vld_once", 32'(vec_vld), 32'd0);
    tick();

    // 2: STD=0, stall on 5th write until commit, accepted the cycle after.
    ctrl_write(2'd0);
    for (int i = 0; i < 4; i++) vec_write(32'hA0 + 32'(i));
    adr = 2'd1; dat_i = 32'hA4; stb = 1'b1; we = 1'b1;
    sample();
    check("t2_full",   32'(vec_full), 32'd1);
    check("t2_stall0", 32'(ack),      32'd0);
    tick();
    sample();
    check("t2_stall1", 32'(ack), 32'd0);
    tick();
    vec_ld = 1'b1;
    exp_q.push_back(model_shadow);
    sample();
    check("t2_stall_ld", 32'(ack), 32'd0);
    tick();
    vec_ld = 1'b0;
    sample();
    check("t2_ack_after", 32'(ack), 32'd1);
    tick();
    idle();
    model_shadow = {model_shadow[VEC_W-DW-1:0], 32'hA4};
    for (int i = 1; i <= 3; i++) begin
      sample();
      check("t2_cnt_one", 32'(vec_full), 32'd0);
      tick();
      vec_write(32'hB0 + 32'(i));
    end
    sample();
    check("t2_refull", 32'(vec_full), 32'd1);
    tick();
    commit(1'b1);

    // 3: STD=2, partial fill, failed commit, CLR, then full 128-word fill.
    ctrl_write(2'd2);
    for (int i = 0; i < 10; i++) vec_write(32'hC000 + 32'(i));
    commit(1'b0);
    sample();
    check("t3_no_vld",   32'(vec_vld),   32'd0);
    check("t3_alloc_kp", alloc_vec[31:0], 32'hB3);
    tick();
    read_status(32'h6000_000A, "t3_status_err");
    clr_write();
    read_status(32'h2000_0000, "t3_status_clr");
    for (int i = 0; i < 128; i++) begin
      vec_write(32'h5A00_0000 + 32'(i));
      sample();
      check("t3_full", 32'(vec_full), 32'(i == 127));
      tick();
    end
    commit(1'b1);

    // 4: STD=3 is always full; writes stall, VEC_LD commits the zero shadow.
    ctrl_write(2'd3);
    adr = 2'd1; dat_i = 32'hDEAD_BEEF; stb = 1'b1; we = 1'b1;
    sample();
    check("t4_full",  32'(vec_full), 32'd1);
    check("t4_stall", 32'(ack),      32'd0);
    tick();
    idle();
    commit(1'b1);
    sample();
    check("t4_std", 32'(std_o), 32'd3);
    tick();

    // 5: reset mid-fill together with VEC_LD.
    ctrl_write(2'd1);
    for (int i = 0; i < 7; i++) vec_write(32'hE0 + 32'(i));
    rst = 1'b1;
    vec_ld = 1'b1;
    tick();
    rst = 1'b0;
    vec_ld = 1'b0;
    model_shadow = '0;
    sample();
    check("t5_std",  32'(std_o),    32'd0);
    check("t5_full", 32'(vec_full), 32'd0);
    check("t5_vld",  32'(vec_vld),  32'd0);
    for (int w = 0; w < NW; w++) check("t5_alloc", alloc_vec[w*DW +: DW], 32'd0);
    tick();
    read_status(32'h0000_0000, "t5_status");

    // 6: VEC_LD and CTRL write in the same cycle while full.
    for (int i = 0; i < 4; i++) vec_write(32'hF0 + 32'(i));
    vec_ld = 1'b1;
    adr = 2'd0; dat_i = 32'd2; stb = 1'b1; we = 1'b1;
    exp_q.push_back(model_shadow);
    $display("VEC_LD + WR CTRL std=2");
    tick();
    idle();
    model_shadow = '0;
    sample();
    check("t6_vld",  32'(vec_vld),   32'd1);
    check("t6_std",  32'(std_o),     32'd2);
    check("t6_cnt",  32'(vec_full),  32'd0);
    check("t6_last", alloc_vec[31:0], 32'hF3);
    tick();
    read_status(32'h2000_0000, "t6_status");

    tick();
    tick();
    sample();
    check("q_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
